oled_spi_receiver: RTL and testbench
====================================

# oled_spi_receiver

Serial-to-parallel decoder for the 4-wire OLED SPI link (CS, SCLK, SDIN, D/C) that the OLED display driver emits toward the 96x64 RGB565 panel. It reconstructs command bytes and pixel writes (index + 16-bit colour) in the 100 MHz domain. It sits on the far end of the JC Pmod lines and serves two purposes: hardware loopback checking of the display path, and a pixel-accurate frame monitor for simulation.

## Interface
Parameters:
- SYNC_STAGES, 2: synchroniser depth applied to every SPI input (minimum 2).
- PIXELS, 6144: pixels per frame (96x64); the pixel index wraps at this count.

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- cs_n  in  1  SPI chip select, active low, asynchronous to CLK100MHZ.
- sclk  in  1  SPI clock, idle high; ≤ CLK100MHZ/8.
- sdin  in  1  SPI data, MSB first, sampled on the sclk rising edge.
- dc  in  1  data/command select (0 = command, 1 = data), sampled with bit 0 of each byte.
- cmd_byte  out  8  last received command byte.
- cmd_valid  out  1  one-cycle strobe; cmd_byte is updated on that same cycle.
- pixel_index  out  13  index of the pixel just written (0..PIXELS-1).
- pixel_data  out  16  RGB565 value, first received byte in bits [15:8].
- pixel_valid  out  1  one-cycle strobe qualifying pixel_index and pixel_data.
- frame_done  out  1  one-cycle strobe, coincident with the pixel_valid for index PIXELS-1.
- short_byte_err  out  1  sticky; set when cs_n rises with a partial byte pending. Cleared only by reset.

## Operation
- Input path: cs_n, sclk, sdin and dc each pass through SYNC_STAGES flops. A further flop on synced sclk gives edge detection; a rise is sclk_s=1 and sclk_q=0.
- The shift register and 3-bit bit counter advance only on a detected sclk rise while synced cs_n=0.
- After the 8th bit (bit counter wraps 7→0), the byte is complete. dc is captured from the same synchronised sample as that last bit.
- Command byte (dc=0):
  - cmd_byte loads and cmd_valid pulses.
  - The half-pixel flag clears and the pixel pointer resets to 0.
- Data byte (dc=1), two-state pairing FSM:
  - HI state: stores the byte as the high byte, then moves to LO.
  - LO state: forms {hi, byte} and drives pixel_data, pixel_index = pointer, pixel_valid=1. Then returns to HI.
  - Pointer increments after each pixel. From PIXELS-1 it wraps to 0, and frame_done pulses with that pixel.
- Synced cs_n rising:
  - Bit counter and shift register clear.
  - If the bit counter was ≠0, short_byte_err sets.
  - The pairing FSM state and pointer are kept across cs_n toggles, because the driver may deselect between bytes.
- A cs_n rise and an sclk rise in the same cycle: the cs_n rise takes priority and the bit is discarded.
- Reset, including mid-byte or mid-pixel:
  - All outputs go to 0 (cmd_byte=0x00, pixel_index=0, pixel_data=0x0000, all strobes 0, short_byte_err=0).
  - FSM returns to HI, pointer to 0, and bit counter to 0.
- The block never back-pressures. Consumers must accept each strobe on the cycle it is asserted.

## Timing
- Latency: a strobe (cmd_valid or pixel_valid) asserts SYNC_STAGES+1 CLK100MHZ cycles after the sclk rising edge carrying bit 0 of the byte. With default parameters this is 3 cycles.
- Each strobe lasts exactly 1 cycle. Data outputs hold their values until the next strobe.
- At the maximum sclk of CLK/8, a byte spans ≥64 cycles, so consecutive strobes are ≥64 cycles apart.
- sdin and dc must be stable for ≥2 CLK100MHZ cycles around each sclk rise. Skew between the sdin and sclk synchronisers is absorbed because both use equal depth.
- cs_n setup before the first sclk fall must be ≥ SYNC_STAGES+1 cycles.

## Test plan
- Command 0xAF (dc=0), sclk = CLK/16: cmd_valid=1 for one cycle, cmd_byte=0xAF, 3 cycles after the last sclk rise. pixel_valid stays 0.
- Data bytes 0xF8, 0x00 (dc=1): a single pixel_valid with pixel_index=0 and pixel_data=0xF800. A further 0x07, 0xE0 gives index 1, data 0x07E0.
- 6144 data pairs 0x001F: pixel_valid seen 6144 times, and frame_done coincides only with index 6143. The 6145th pair reports index 0.
- Send 5 bits, raise cs_n, then send full byte 0x55 (dc=1) and 0xAA (dc=1): short_byte_err=1, and the pixel is 0x55AA at the current index. The partial bits do not leak into it.
- Send one data byte 0x12, then command 0x15, then data 0x34, 0x56: no pixel from 0x12, cmd_valid with 0x15, then pixel index 0 with data 0x3456.
- Assert reset mid-byte and after a high byte: all outputs are 0 and short_byte_err=0. The next pair 0xAB, 0xCD yields index 0, data 0xABCD.

Source files
------------

// File: rtl/oled_spi_receiver_if.sv
// oled_spi_receiver_if
// Bundles the 4-wire OLED SPI link (cs_n, sclk, sdin, dc) with the decoded
// command/pixel outputs of the receiver.
//   slave  : the receiver (samples the SPI wires, drives decoded outputs)
//   master : the link driver / monitor (drives SPI wires, observes outputs)
interface oled_spi_receiver_if;
    logic        cs_n;
    logic        sclk;
    logic        sdin;
    logic        dc;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic [12:0] pixel_index;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic        short_byte_err;

    modport slave (
        input  cs_n, sclk, sdin, dc,
        output cmd_byte, cmd_valid, pixel_index, pixel_data, pixel_valid,
               frame_done, short_byte_err
    );

    modport master (
        output cs_n, sclk, sdin, dc,
        input  cmd_byte, cmd_valid, pixel_index, pixel_data, pixel_valid,
               frame_done, short_byte_err
    );
endinterface

// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver
// Serial-to-parallel decoder for the OLED SPI link, running in the 100 MHz
// domain. Reconstructs command bytes (dc=0) and RGB565 pixel writes built
// from pairs of data bytes (dc=1), with a wrapping pixel pointer.
// Ports:
//   CLK100MHZ : system clock
//   reset     : asynchronous, active-high reset
//   bus       : oled_spi_receiver_if.slave
//               in : cs_n, sclk, sdin, dc (asynchronous SPI wires)
//               out: cmd_byte/cmd_valid, pixel_index/pixel_data/pixel_valid,
//                    frame_done, short_byte_err (sticky)
module oled_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int PIXELS      = 6144
) (
    input  logic                   CLK100MHZ,
    input  logic                   reset,
    oled_spi_receiver_if.slave     bus
);

    typedef enum logic {
        ST_HI = 1'b0,
        ST_LO = 1'b1
    } pair_state_e;

    // Synchronisers: bit 0 samples the pin, bit SYNC_STAGES-1 is the synced value
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sdin_sync_q, sdin_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q,   dc_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    logic [6:0]  shift_q,   shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    pair_state_e state_q,   state_d;
    logic [7:0]  hi_q,      hi_d;
    logic [12:0] ptr_q,     ptr_d;

    logic [7:0]  cmd_byte_q,    cmd_byte_d;
    logic        cmd_valid_q,   cmd_valid_d;
    logic [12:0] pix_idx_q,     pix_idx_d;
    logic [15:0] pix_data_q,    pix_data_d;
    logic        pix_valid_q,   pix_valid_d;
    logic        frame_done_q,  frame_done_d;
    logic        err_q,         err_d;

    logic        cs_s, sclk_s, sdin_s, dc_s;
    logic        sclk_rise, cs_rise;
    logic [7:0]  byte_w;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sdin_s = sdin_sync_q[SYNC_STAGES-1];
    assign dc_s   = dc_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev_q;
    // The byte as it stands once the current bit is shifted in
    assign byte_w    = {shift_q, sdin_s};

    always_comb begin
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        sdin_sync_d  = {sdin_sync_q[SYNC_STAGES-2:0], bus.sdin};
        dc_sync_d    = {dc_sync_q[SYNC_STAGES-2:0],   bus.dc};
        sclk_prev_d  = sclk_s;
        cs_prev_d    = cs_s;

        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        state_d      = state_q;
        hi_d         = hi_q;
        ptr_d        = ptr_q;
        cmd_byte_d   = cmd_byte_q;
        pix_idx_d    = pix_idx_q;
        pix_data_d   = pix_data_q;
        err_d        = err_q;
        cmd_valid_d  = 1'b0;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        // Deselect wins over a coincident sclk rise; pairing state and pointer
        // survive because the driver may deselect between bytes.
        if (cs_rise) begin
            shift_d   = '0;
            bit_cnt_d = 3'd0;
            if (bit_cnt_q != 3'd0) begin
                err_d = 1'b1;
            end
        end else if (sclk_rise) begin
            shift_d   = byte_w[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                if (!dc_s) begin
                    cmd_byte_d  = byte_w;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_HI;
                    ptr_d       = 13'd0;
                end else if (state_q == ST_HI) begin
                    hi_d    = byte_w;
                    state_d = ST_LO;
                end else begin
                    pix_data_d  = {hi_q, byte_w};
                    pix_idx_d   = ptr_q;
                    pix_valid_d = 1'b1;
                    state_d     = ST_HI;
                    if (ptr_q == 13'(PIXELS - 1)) begin
                        ptr_d        = 13'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 13'd1;
                    end
                end
            end
        end
    end

    // Sync chains reset to the idle line levels (cs_n high, sclk high) so that
    // leaving reset never looks like a deselect or a clock edge.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            cs_sync_q    <= '1;
            sclk_sync_q  <= '1;
            sdin_sync_q  <= '0;
            dc_sync_q    <= '0;
            sclk_prev_q  <= 1'b1;
            cs_prev_q    <= 1'b1;
            shift_q      <= '0;
            bit_cnt_q    <= 3'd0;
            state_q      <= ST_HI;
            hi_q         <= 8'd0;
            ptr_q        <= 13'd0;
            cmd_byte_q   <= 8'd0;
            cmd_valid_q  <= 1'b0;
            pix_idx_q    <= 13'd0;
            pix_data_q   <= 16'd0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            sdin_sync_q  <= sdin_sync_d;
            dc_sync_q    <= dc_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            state_q      <= state_d;
            hi_q         <= hi_d;
            ptr_q        <= ptr_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            pix_idx_q    <= pix_idx_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.cmd_byte       = cmd_byte_q;
    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.pixel_index    = pix_idx_q;
    assign bus.pixel_data     = pix_data_q;
    assign bus.pixel_valid    = pix_valid_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.short_byte_err = err_q;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// tb_oled_spi_receiver
// Directed bench for oled_spi_receiver. A byte-level model (event queue of
// completed bytes / deselects, each due SYNC_STAGES+1 cycles after its
// launching sclk/cs_n edge) predicts every output on every cycle; literal
// checks after each scenario pin the model. The frame length is reduced to
// PIX pixels so a full frame wrap fits in a short run.
module tb_oled_spi_receiver;
    localparam int SS  = 2;
    localparam int PIX = 24;
    localparam int LAT = SS + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    oled_spi_receiver_if ifc ();

    oled_spi_receiver #(.SYNC_STAGES(SS), .PIXELS(PIX)) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (ifc.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef enum {EV_CMD, EV_DATA, EV_CSUP} ev_kind_e;
    typedef struct {
        int         due;
        ev_kind_e   kind;
        logic [7:0] b;
        logic       partial;
    } ev_t;
    ev_t evq[$];

    // model state
    logic [7:0]  m_cmd;
    logic [12:0] m_idx;
    logic [15:0] m_data;
    logic        m_err;
    logic        m_have_hi;
    logic [7:0]  m_hi;
    int          m_ptr;
    int          partial_bits;

    // observations of the DUT, used only by the literal checks
    int          cmd_cnt = 0, pix_cnt = 0, fd_cnt = 0;
    int          cmd_cyc = 0, last_rise_cyc = 0;
    logic [7:0]  seen_cmd = 8'h00;
    logic [12:0] seen_idx = 13'd0;
    logic [15:0] seen_data = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cmd = 8'h00; m_idx = 13'd0; m_data = 16'h0000; m_err = 1'b0;
        m_have_hi = 1'b0; m_hi = 8'h00; m_ptr = 0; partial_bits = 0;
        evq.delete();
    endtask

    initial model_reset();

    // Per-cycle compare against the model
    always @(negedge clk) begin : compare
        logic ecv, epv, efd;
        ev_t  ev;
        ecv = 1'b0; epv = 1'b0; efd = 1'b0;
        while (evq.size() > 0 && evq[0].due <= cyc) begin
            ev = evq.pop_front();
            case (ev.kind)
                EV_CMD: begin
                    m_cmd = ev.b; ecv = 1'b1; m_have_hi = 1'b0; m_ptr = 0;
                end
                EV_DATA: begin
                    if (!m_have_hi) begin
                        m_hi = ev.b; m_have_hi = 1'b1;
                    end else begin
                        m_data = {m_hi, ev.b};
                        m_idx  = 13'(m_ptr);
                        epv    = 1'b1;
                        efd    = (m_ptr == PIX - 1);
                        m_ptr  = (m_ptr + 1) % PIX;
                        m_have_hi = 1'b0;
                    end
                end
                default: if (ev.partial) m_err = 1'b1;
            endcase
        end
        chk("cmd_valid",      32'(ifc.cmd_valid),      32'(ecv));
        chk("cmd_byte",       32'(ifc.cmd_byte),       32'(m_cmd));
        chk("pixel_valid",    32'(ifc.pixel_valid),    32'(epv));
        chk("pixel_index",    32'(ifc.pixel_index),    32'(m_idx));
        chk("pixel_data",     32'(ifc.pixel_data),     32'(m_data));
        chk("frame_done",     32'(ifc.frame_done),     32'(efd));
        chk("short_byte_err", 32'(ifc.short_byte_err), 32'(m_err));
        if (ifc.cmd_valid) begin
            cmd_cnt++; seen_cmd = ifc.cmd_byte; cmd_cyc = cyc;
        end
        if (ifc.pixel_valid) begin
            pix_cnt++; seen_idx = ifc.pixel_index; seen_data = ifc.pixel_data;
        end
        if (ifc.frame_done) fd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the top n bits of b MSB first; sclk half period = h clocks.
    task automatic send_bits(input logic [7:0] b, input int n, input logic d, input int h);
        for (int i = 7; i > 7 - n; i--) begin
            ifc.sclk = 1'b0; ifc.sdin = b[i]; ifc.dc = d;
            tick(h);
            ifc.sclk = 1'b1;
            if (i == 0) begin
                last_rise_cyc = cyc;
                evq.push_back('{cyc + LAT, d ? EV_DATA : EV_CMD, b, 1'b0});
            end
            tick(h);
        end
        partial_bits = (partial_bits + n) % 8;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input int h);
        send_bits(b, 8, d, h);
        tick(2);
    endtask

    task automatic cs_up();
        ifc.cs_n = 1'b1;
        evq.push_back('{cyc + LAT, EV_CSUP, 8'h00, partial_bits != 0});
        partial_bits = 0;
        tick(6);
    endtask

    task automatic cs_down();
        ifc.cs_n = 1'b0;
        tick(SS + 2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick(1);
        chk("rst cmd_byte",    32'(ifc.cmd_byte),       32'h0);
        chk("rst cmd_valid",   32'(ifc.cmd_valid),      32'h0);
        chk("rst pixel_index", 32'(ifc.pixel_index),    32'h0);
        chk("rst pixel_data",  32'(ifc.pixel_data),     32'h0);
        chk("rst pixel_valid", 32'(ifc.pixel_valid),    32'h0);
        chk("rst short_err",   32'(ifc.short_byte_err), 32'h0);
        tick(1);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pc;
        ifc.cs_n = 1'b1; ifc.sclk = 1'b1; ifc.sdin = 1'b0; ifc.dc = 1'b0;
        @(posedge clk); #1;
        do_reset();
        cs_down();

        // command 0xAF at CLK/16
        send_byte(8'hAF, 1'b0, 8);
        tick(4);
        chk("cmd AF byte",    32'(seen_cmd), 32'hAF);
        chk("cmd AF count",   32'(cmd_cnt),  32'd1);
        chk("cmd AF nopix",   32'(pix_cnt),  32'd0);
        chk("cmd AF latency", 32'(cmd_cyc - last_rise_cyc), 32'd3);

        // two pixels
        send_byte(8'hF8, 1'b1, 8);
        send_byte(8'h00, 1'b1, 8);
        chk("pix0 count", 32'(pix_cnt),   32'd1);
        chk("pix0 index", 32'(seen_idx),  32'd0);
        chk("pix0 data",  32'(seen_data), 32'hF800);
        send_byte(8'h07, 1'b1, 8);
        send_byte(8'hE0, 1'b1, 8);
        chk("pix1 index", 32'(seen_idx),  32'd1);
        chk("pix1 data",  32'(seen_data), 32'h07E0);

        // half pixel abandoned by a command
        send_byte(8'h12, 1'b1, 8);
        send_byte(8'h15, 1'b0, 8);
        chk("half pix none", 32'(pix_cnt),  32'd2);
        chk("cmd 15 byte",   32'(seen_cmd), 32'h15);
        send_byte(8'h34, 1'b1, 8);
        send_byte(8'h56, 1'b1, 8);
        chk("after cmd index", 32'(seen_idx),  32'd0);
        chk("after cmd data",  32'(seen_data), 32'h3456);

        // full frame at CLK/8, then one more pair
        send_byte(8'h15, 1'b0, 4);
        pc = pix_cnt;
        for (int k = 0; k < PIX; k++) begin
            send_byte(8'h00, 1'b1, 4);
            send_byte(8'h1F, 1'b1, 4);
        end
        chk("frame pixels",  32'(pix_cnt - pc), 32'(PIX));
        chk("frame last idx",32'(seen_idx),     32'(PIX - 1));
        chk("frame done cnt",32'(fd_cnt),       32'd1);
        chk("frame data",    32'(seen_data),    32'h001F);
        send_byte(8'h00, 1'b1, 4);
        send_byte(8'h1F, 1'b1, 4);
        chk("wrap idx",     32'(seen_idx), 32'd0);
        chk("wrap fd cnt",  32'(fd_cnt),   32'd1);

        // partial byte then deselect
        send_bits(8'hE8, 5, 1'b1, 8);
        cs_up();
        cs_down();
        send_byte(8'h55, 1'b1, 8);
        send_byte(8'hAA, 1'b1, 8);
        chk("short err",   32'(ifc.short_byte_err), 32'd1);
        chk("short index", 32'(seen_idx),           32'd1);
        chk("short data",  32'(seen_data),          32'h55AA);

        // reset mid-byte
        send_bits(8'hC3, 4, 1'b1, 8);
        do_reset();
        send_byte(8'hAB, 1'b1, 8);
        send_byte(8'hCD, 1'b1, 8);
        chk("rst1 index", 32'(seen_idx),           32'd0);
        chk("rst1 data",  32'(seen_data),          32'hABCD);
        chk("rst1 err",   32'(ifc.short_byte_err), 32'd0);

        // reset after a high byte
        send_byte(8'h99, 1'b1, 8);
        do_reset();
        send_byte(8'hAB, 1'b1, 8);
        send_byte(8'hCD, 1'b1, 8);
        chk("rst2 index", 32'(seen_idx),  32'd0);
        chk("rst2 data",  32'(seen_data), 32'hABCD);

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
